afe_spi_cfg_sequencer: RTL and testbench
========================================

// Module: afe_spi_cfg_sequencer
// PURPOSE
//  Power-up configuration engine for the AFE: walks a NUM_WORDS-entry combinational config table
//  (e.g. the afe7225 LUT ROM) and shifts each WORD_W-bit frame out on a 4-wire SPI bus, MSB first.
//  Generalises the fixed table: parametrised width/depth/SCLK rate, post-soft-reset wait, readback
//  frames and a single-word runtime write/read port. Sits between the top-level init FSM and AFE pins.
// PARAMETERS
//  WORD_W       20   SPI frame width; bit WORD_W-1 = R/W (1 = read)
//  DATA_W       8    data field width = frame bits [DATA_W-1:0]
//  ADDR_W       6    table index width
//  NUM_WORDS    44   table entries sent per run (1..2**ADDR_W)
//  CLK_DIV      4    i_clk cycles per SCLK half-period (>=1)
//  GAP_CYC      16   i_clk cycles CSn held high between frames (>=1)
//  RST_IDX      0    table index of the soft-reset frame
//  RST_WAIT_CYC 1024 gap used instead of GAP_CYC after frame RST_IDX
// PORTS
//  i_clk       in  1       system clock
//  i_rst       in  1       synchronous active-high reset
//  i_start     in  1       pulse: run the full table
//  i_req_valid in  1       single-frame request (valid/ready)
//  i_req_data  in  WORD_W  single frame to send
//  o_req_ready out 1       high in IDLE only
//  o_rom_addr  out ADDR_W  table index to ROM
//  i_rom_data  in  WORD_W  ROM word (combinational, same cycle)
//  o_busy      out 1       high from accept to return to IDLE
//  o_done      out 1       1-cycle pulse when table run completes
//  o_rd_valid  out 1       1-cycle pulse: read frame finished
//  o_rd_data   out DATA_W  captured read data
//  o_spi_csn   out 1       chip select, active low
//  o_spi_sclk  out 1       SPI clock, CPOL=0/CPHA=0
//  o_spi_sdo   out 1       MOSI
//  i_spi_sdi   in  1       MISO
// BEHAVIOUR
//  Reset: csn=1, sclk=0, sdo=0, busy=0, done=0, rd_valid=0, rd_data=0, rom_addr=0, FSM->IDLE.
//  Reset mid-frame aborts: csn high and sclk low on the first edge with i_rst=1; no done/rd_valid.
//  States: IDLE -> FETCH -> LOAD -> SHIFT -> GAP -> (NEXT -> FETCH | DONE) ; DONE -> IDLE.
//  IDLE: i_start has priority over i_req_valid in the same cycle; the request is accepted when
//   valid&&ready (ready=1 only in IDLE). Both are ignored while busy.
//  FETCH (1 cycle): latch i_rom_data (table mode) or i_req_data (single mode) into the shift reg.
//  LOAD (CLK_DIV cycles): csn=0, sclk=0, sdo=frame[WORD_W-1].
//  SHIFT: per bit: CLK_DIV cycles sclk=1, then CLK_DIV cycles sclk=0. sdi is sampled on the
//   rising edge; sdo advances on the falling edge. The last bit's low phase is the CS hold.
//   CSn low time = CLK_DIV*(1+2*WORD_W) cycles (164 at defaults).
//  GAP: csn=1, sdo=0; lasts RST_WAIT_CYC if table mode and index==RST_IDX, else GAP_CYC.
//   If the frame R/W bit=1: o_rd_data = last DATA_W sampled bits, o_rd_valid pulses on the
//   first GAP cycle.
//  NEXT: if index==NUM_WORDS-1 -> DONE, else index+1 -> FETCH. Single mode goes GAP -> IDLE
//   without o_done. rom_addr = index and returns to 0 in DONE.
//  DONE: o_done=1 for 1 cycle; busy drops on the following cycle (IDLE).
//  Counters: divider width clog2(CLK_DIV); bit counter clog2(WORD_W+1); gap counter
//   clog2(max(GAP_CYC,RST_WAIT_CYC)+1). No wrap in range; the index never exceeds NUM_WORDS-1.
// STRUCTURE
//  Package afe_cfg_pkg: FSM state encoding, R/W bit position, default timing constants.
//  Sub-module afe_spi_shifter: divider + shift reg + sdi capture; load/start in, bit_done/frame_done out.
//  Top level: sequencing FSM, index and gap counters, request arbitration.
// TESTING
//  1 Reset then i_start with NUM_WORDS=3, ROM={00002,00000,30B80}, RST_WAIT_CYC=40 -> 3 CSn frames
//    of 164 cycles; sdo bits match; gaps 40,16; o_done pulse once; busy low after.
//  2 Readback: single req 0x8_0055 (R/W=1), sdi model drives 0xA5 in the data field -> o_rd_valid
//    pulse, o_rd_data=8'hA5; no o_done.
//  3 i_start and i_req_valid together in IDLE -> table run; request held until ready returns, then
//    sent once.
//  4 i_start pulses during a run -> ignored; exactly NUM_WORDS frames.
//  5 i_rst asserted at bit 10 of frame 2 -> next cycle csn=1, sclk=0, busy=0; a new i_start
//    restarts from index 0.
//  6 CLK_DIV=1, WORD_W=16 -> SCLK period 2 clk, CSn low 33 cycles, data correct.

Source files
------------

// File: rtl/afe_cfg_pkg.sv
// Shared types and default constants for the AFE SPI configuration sequencer.
package afe_cfg_pkg;

  // Sequencer FSM encoding
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_GAP   = 3'd4,
    ST_NEXT  = 3'd5,
    ST_DONE  = 3'd6
  } afe_state_e;

  // Default frame geometry and timing
  localparam int unsigned DEF_WORD_W       = 20;
  localparam int unsigned DEF_DATA_W       = 8;
  localparam int unsigned DEF_ADDR_W       = 6;
  localparam int unsigned DEF_NUM_WORDS    = 44;
  localparam int unsigned DEF_CLK_DIV      = 4;
  localparam int unsigned DEF_GAP_CYC      = 16;
  localparam int unsigned DEF_RST_IDX      = 0;
  localparam int unsigned DEF_RST_WAIT_CYC = 1024;

  // R/W flag sits in the frame MSB (1 = read)
  function automatic int unsigned rw_pos(input int unsigned word_w);
    return word_w - 1;
  endfunction

  // Counter width that stays >= 1 even for a modulus of 1
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/afe_spi_shifter.sv
// SPI mode-0 frame shifter: half-period divider, MSB-first shift register, MISO capture.
module afe_spi_shifter
  import afe_cfg_pkg::*;
#(
  parameter int unsigned WORD_W  = DEF_WORD_W,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned CLK_DIV = DEF_CLK_DIV
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [WORD_W-1:0] i_frame,
  input  logic              i_sdi,
  output logic              o_sclk,
  output logic              o_sdo,
  output logic              o_sclk_rise_c,
  output logic              o_frame_done_c,
  output logic [DATA_W-1:0] o_rx_data
);

  localparam int unsigned DIV_W = cnt_w(CLK_DIV);
  localparam int unsigned BIT_W = $clog2(WORD_W + 1);

  logic              r_active;
  logic              r_sclk;
  logic [DIV_W-1:0]  r_div;
  logic [BIT_W-1:0]  r_bit;
  logic [WORD_W-1:0] r_shreg;
  logic [DATA_W-1:0] r_rx;

  logic w_half_end;
  logic w_last;
  logic w_fall;

  // Half-period boundaries; the low phase before bit 0 doubles as the CSn setup time
  assign w_half_end     = r_active && (r_div == DIV_W'(CLK_DIV - 1));
  assign w_last         = (r_bit == BIT_W'(WORD_W));
  assign o_sclk_rise_c  = w_half_end && !r_sclk && !w_last;
  assign o_frame_done_c = w_half_end && !r_sclk && w_last;
  assign w_fall         = w_half_end && r_sclk;

  assign o_sclk    = r_sclk;
  assign o_sdo     = r_shreg[WORD_W-1];
  assign o_rx_data = r_rx;

  // Divider, bit counter, shift and capture registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_active <= 1'b0;
      r_sclk   <= 1'b0;
      r_div    <= '0;
      r_bit    <= '0;
      r_shreg  <= '0;
      r_rx     <= '0;
    end else if (i_load) begin
      r_active <= 1'b1;
      r_sclk   <= 1'b0;
      r_div    <= '0;
      r_bit    <= '0;
      r_shreg  <= i_frame;
    end else if (r_active) begin
      r_div <= w_half_end ? '0 : r_div + 1'b1;
      if (o_sclk_rise_c) begin
        r_sclk <= 1'b1;
        r_rx   <= {r_rx[DATA_W-2:0], i_sdi};
      end
      if (w_fall) begin
        r_sclk  <= 1'b0;
        r_bit   <= r_bit + 1'b1;
        r_shreg <= {r_shreg[WORD_W-2:0], 1'b0};
      end
      if (o_frame_done_c) begin
        r_active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/afe_spi_cfg_sequencer.sv
// AFE power-up configuration engine: walks the config table or sends one runtime frame over SPI.
module afe_spi_cfg_sequencer
  import afe_cfg_pkg::*;
#(
  parameter int unsigned WORD_W       = DEF_WORD_W,
  parameter int unsigned DATA_W       = DEF_DATA_W,
  parameter int unsigned ADDR_W       = DEF_ADDR_W,
  parameter int unsigned NUM_WORDS    = DEF_NUM_WORDS,
  parameter int unsigned CLK_DIV      = DEF_CLK_DIV,
  parameter int unsigned GAP_CYC      = DEF_GAP_CYC,
  parameter int unsigned RST_IDX      = DEF_RST_IDX,
  parameter int unsigned RST_WAIT_CYC = DEF_RST_WAIT_CYC
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_req_valid,
  input  logic [WORD_W-1:0] i_req_data,
  output logic              o_req_ready,
  output logic [ADDR_W-1:0] o_rom_addr,
  input  logic [WORD_W-1:0] i_rom_data,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_spi_csn,
  output logic              o_spi_sclk,
  output logic              o_spi_sdo,
  input  logic              i_spi_sdi
);

  localparam int unsigned       RW_POS   = rw_pos(WORD_W);
  localparam int unsigned       GAP_MAX  = (GAP_CYC > RST_WAIT_CYC) ? GAP_CYC : RST_WAIT_CYC;
  localparam int unsigned       GAP_W    = $clog2(GAP_MAX + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);
  localparam logic [ADDR_W-1:0] RST_ADDR = ADDR_W'(RST_IDX);

  afe_state_e        r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_index, w_index_nxt;
  logic              r_table, w_table_nxt;
  logic [WORD_W-1:0] r_req_frame, w_req_frame_nxt;
  logic              r_rw, w_rw_nxt;
  logic [GAP_W-1:0]  r_gap_cnt, w_gap_cnt_nxt;
  logic              r_csn, w_csn_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_done, w_done_nxt;
  logic              r_ready, w_ready_nxt;
  logic              r_rd_valid, w_rd_valid_nxt;
  logic [DATA_W-1:0] r_rd_data, w_rd_data_nxt;

  logic              w_load;
  logic [WORD_W-1:0] w_frame;
  logic              w_sclk;
  logic              w_sdo;
  logic              w_sclk_rise;
  logic              w_frame_done;
  logic [DATA_W-1:0] w_rx_data;

  afe_spi_shifter #(
    .WORD_W  (WORD_W),
    .DATA_W  (DATA_W),
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_load         (w_load),
    .i_frame        (w_frame),
    .i_sdi          (i_spi_sdi),
    .o_sclk         (w_sclk),
    .o_sdo          (w_sdo),
    .o_sclk_rise_c  (w_sclk_rise),
    .o_frame_done_c (w_frame_done),
    .o_rx_data      (w_rx_data)
  );

  // Table word comes straight from the ROM; single-mode frame was captured at the handshake
  assign w_frame = r_table ? i_rom_data : r_req_frame;

  // State and registered-output update
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_index     <= '0;
      r_table     <= 1'b0;
      r_req_frame <= '0;
      r_rw        <= 1'b0;
      r_gap_cnt   <= '0;
      r_csn       <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ready     <= 1'b1;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_index     <= w_index_nxt;
      r_table     <= w_table_nxt;
      r_req_frame <= w_req_frame_nxt;
      r_rw        <= w_rw_nxt;
      r_gap_cnt   <= w_gap_cnt_nxt;
      r_csn       <= w_csn_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_ready     <= w_ready_nxt;
      r_rd_valid  <= w_rd_valid_nxt;
      r_rd_data   <= w_rd_data_nxt;
    end
  end

  // Next-state, counters and output decode
  always_comb begin
    w_state_nxt     = r_state;
    w_index_nxt     = r_index;
    w_table_nxt     = r_table;
    w_req_frame_nxt = r_req_frame;
    w_rw_nxt        = r_rw;
    w_gap_cnt_nxt   = r_gap_cnt;
    w_rd_valid_nxt  = 1'b0;
    w_rd_data_nxt   = r_rd_data;
    w_load          = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_table_nxt = 1'b1;
          w_index_nxt = '0;
          w_state_nxt = ST_FETCH;
        end else if (i_req_valid && r_ready) begin
          w_table_nxt     = 1'b0;
          w_req_frame_nxt = i_req_data;
          w_state_nxt     = ST_FETCH;
        end
      end
      ST_FETCH: begin
        w_load      = 1'b1;
        w_rw_nxt    = w_frame[RW_POS];
        w_state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (w_sclk_rise) begin
          w_state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (w_frame_done) begin
          w_state_nxt   = ST_GAP;
          w_gap_cnt_nxt = (r_table && (r_index == RST_ADDR)) ? GAP_W'(RST_WAIT_CYC - 1)
                                                             : GAP_W'(GAP_CYC - 1);
          if (r_rw) begin
            w_rd_valid_nxt = 1'b1;
            w_rd_data_nxt  = w_rx_data;
          end
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == '0) begin
          w_state_nxt = r_table ? ST_NEXT : ST_IDLE;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - 1'b1;
        end
      end
      ST_NEXT: begin
        if (r_index == LAST_IDX) begin
          w_index_nxt = '0;
          w_state_nxt = ST_DONE;
        end else begin
          w_index_nxt = r_index + 1'b1;
          w_state_nxt = ST_FETCH;
        end
      end
      ST_DONE: begin
        w_index_nxt = '0;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    w_csn_nxt   = !((w_state_nxt == ST_LOAD) || (w_state_nxt == ST_SHIFT));
    w_busy_nxt  = (w_state_nxt != ST_IDLE);
    w_done_nxt  = (w_state_nxt == ST_DONE);
    w_ready_nxt = (w_state_nxt == ST_IDLE);
  end

  assign o_req_ready = r_ready;
  assign o_rom_addr  = r_index;
  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_rd_valid  = r_rd_valid;
  assign o_rd_data   = r_rd_data;
  assign o_spi_csn   = r_csn;
  assign o_spi_sclk  = w_sclk;
  assign o_spi_sdo   = w_sdo;

endmodule

// File: tb/tb_afe_spi_cfg_sequencer.sv
// Directed bench: table runs, readback, arbitration, reset abort, fast-SCLK variant.
module tb_afe_spi_cfg_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- DUT A: 20-bit frames, CLK_DIV=4, 3-word table ----------------
  logic        a_rst, a_start, a_req_valid, a_req_ready;
  logic [19:0] a_req_data, a_rom_data;
  logic [5:0]  a_rom_addr;
  logic        a_busy, a_done, a_rd_valid;
  logic [7:0]  a_rd_data;
  logic        a_csn, a_sclk, a_sdo;
  logic        a_sdi = 1'b0;

  afe_spi_cfg_sequencer #(
    .WORD_W(20), .DATA_W(8), .ADDR_W(6), .NUM_WORDS(3), .CLK_DIV(4),
    .GAP_CYC(16), .RST_IDX(0), .RST_WAIT_CYC(40)
  ) u_dut_a (
    .i_clk(clk), .i_rst(a_rst), .i_start(a_start), .i_req_valid(a_req_valid),
    .i_req_data(a_req_data), .o_req_ready(a_req_ready), .o_rom_addr(a_rom_addr),
    .i_rom_data(a_rom_data), .o_busy(a_busy), .o_done(a_done), .o_rd_valid(a_rd_valid),
    .o_rd_data(a_rd_data), .o_spi_csn(a_csn), .o_spi_sclk(a_sclk), .o_spi_sdo(a_sdo),
    .i_spi_sdi(a_sdi)
  );

  always_comb begin
    case (a_rom_addr)
      6'd0:    a_rom_data = 20'h00002;
      6'd1:    a_rom_data = 20'h00000;
      6'd2:    a_rom_data = 20'h30B80;
      default: a_rom_data = 20'h00000;
    endcase
  end

  // ---------------- DUT B: 16-bit frames, CLK_DIV=1, 2-word table ----------------
  logic        b_rst, b_start, b_req_valid, b_req_ready;
  logic [15:0] b_req_data, b_rom_data;
  logic [1:0]  b_rom_addr;
  logic        b_busy, b_done, b_rd_valid;
  logic [7:0]  b_rd_data;
  logic        b_csn, b_sclk, b_sdo;
  logic        b_sdi;

  afe_spi_cfg_sequencer #(
    .WORD_W(16), .DATA_W(8), .ADDR_W(2), .NUM_WORDS(2), .CLK_DIV(1),
    .GAP_CYC(3), .RST_IDX(0), .RST_WAIT_CYC(5)
  ) u_dut_b (
    .i_clk(clk), .i_rst(b_rst), .i_start(b_start), .i_req_valid(b_req_valid),
    .i_req_data(b_req_data), .o_req_ready(b_req_ready), .o_rom_addr(b_rom_addr),
    .i_rom_data(b_rom_data), .o_busy(b_busy), .o_done(b_done), .o_rd_valid(b_rd_valid),
    .o_rd_data(b_rd_data), .o_spi_csn(b_csn), .o_spi_sclk(b_sclk), .o_spi_sdo(b_sdo),
    .i_spi_sdi(b_sdi)
  );

  assign b_sdi = 1'b0;
  always_comb begin
    case (b_rom_addr)
      2'd0:    b_rom_data = 16'hA5C3;
      2'd1:    b_rom_data = 16'h1234;
      default: b_rom_data = 16'h0000;
    endcase
  end

  // ---------------- Bus monitor + MISO slave model for A ----------------
  logic        a_prev_csn = 1'b1, a_prev_sclk = 1'b0;
  int          a_lo = 0, a_hi = 0, a_bits = 0, a_falls = 0;
  logic [31:0] a_sh = '0;
  logic [19:0] a_resp = '0;
  bit          a_seen = 1'b0;
  logic [31:0] a_frames[$];
  int          a_lows[$], a_gaps[$];
  int          a_done_n = 0, a_rdv_n = 0;

  always @(negedge clk) begin
    if (!a_csn) begin
      if (a_prev_csn) begin
        if (a_seen) a_gaps.push_back(a_hi);
        a_lo = 0; a_sh = '0; a_bits = 0; a_falls = 0;
      end
      a_lo++;
      if (a_sclk && !a_prev_sclk) begin
        a_sh = {a_sh[30:0], a_sdo};
        a_bits++;
      end
      if (!a_sclk && a_prev_sclk) a_falls++;
      a_sdi = (a_falls < 20) ? a_resp[19 - a_falls] : 1'b0;
    end else begin
      if (!a_prev_csn) begin
        a_frames.push_back(a_sh);
        a_lows.push_back(a_lo);
        a_seen = 1'b1;
        a_hi = 0;
      end
      a_hi++;
      a_sdi = 1'b0;
    end
    if (a_done)     a_done_n++;
    if (a_rd_valid) a_rdv_n++;
    a_prev_csn  = a_csn;
    a_prev_sclk = a_sclk;
  end

  // ---------------- Bus monitor for B (also measures SCLK period) ----------------
  logic        b_prev_csn = 1'b1, b_prev_sclk = 1'b0;
  int          b_lo = 0, b_hi = 0, b_bits = 0, b_cyc = 0, b_last_rise = 0;
  int          b_pmin = 1000, b_pmax = 0;
  logic [31:0] b_sh = '0;
  bit          b_seen = 1'b0;
  logic [31:0] b_frames[$];
  int          b_lows[$], b_gaps[$];
  int          b_done_n = 0;

  always @(negedge clk) begin
    b_cyc++;
    if (!b_csn) begin
      if (b_prev_csn) begin
        if (b_seen) b_gaps.push_back(b_hi);
        b_lo = 0; b_sh = '0; b_bits = 0;
      end
      b_lo++;
      if (b_sclk && !b_prev_sclk) begin
        if (b_bits > 0) begin
          if (b_cyc - b_last_rise < b_pmin) b_pmin = b_cyc - b_last_rise;
          if (b_cyc - b_last_rise > b_pmax) b_pmax = b_cyc - b_last_rise;
        end
        b_last_rise = b_cyc;
        b_sh = {b_sh[30:0], b_sdo};
        b_bits++;
      end
    end else begin
      if (!b_prev_csn) begin
        b_frames.push_back(b_sh);
        b_lows.push_back(b_lo);
        b_seen = 1'b1;
        b_hi = 0;
      end
      b_hi++;
    end
    if (b_done) b_done_n++;
    b_prev_csn  = b_csn;
    b_prev_sclk = b_sclk;
  end

  // ---------------- Helpers ----------------
  task automatic clear_a();
    a_frames.delete(); a_lows.delete(); a_gaps.delete();
    a_seen = 1'b0; a_done_n = 0; a_rdv_n = 0;
  endtask

  task automatic pulse_start_a();
    @(negedge clk) a_start = 1'b1;
    @(negedge clk) a_start = 1'b0;
  endtask

  task automatic wait_idle(input bit sel_b, input int budget, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!(sel_b ? b_busy : a_busy)) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  // ---------------- Stimulus ----------------
  initial begin
    bit ok;
    a_rst = 1'b1; a_start = 1'b0; a_req_valid = 1'b0; a_req_data = '0;
    b_rst = 1'b1; b_start = 1'b0; b_req_valid = 1'b0; b_req_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_csn",      32'(a_csn),       32'd1);
    chk("rst_sclk",     32'(a_sclk),      32'd0);
    chk("rst_sdo",      32'(a_sdo),       32'd0);
    chk("rst_busy",     32'(a_busy),      32'd0);
    chk("rst_done",     32'(a_done),      32'd0);
    chk("rst_rd_valid", 32'(a_rd_valid),  32'd0);
    chk("rst_rd_data",  32'(a_rd_data),   32'd0);
    chk("rst_rom_addr", 32'(a_rom_addr),  32'd0);
    chk("rst_ready",    32'(a_req_ready), 32'd1);
    a_rst = 1'b0;
    b_rst = 1'b0;

    // 1: full table run; RST_IDX gap 40 and normal gap 16, each plus NEXT+FETCH with CSn high
    clear_a();
    pulse_start_a();
    chk("t1_busy_after_start",  32'(a_busy),      32'd1);
    chk("t1_ready_while_busy",  32'(a_req_ready), 32'd0);
    wait_idle(1'b0, 3000, "t1_idle_timeout");
    chk("t1_frame_count", 32'(a_frames.size()), 32'd3);
    chk("t1_frame0", a_frames[0], 32'h00002);
    chk("t1_frame1", a_frames[1], 32'h00000);
    chk("t1_frame2", a_frames[2], 32'h30B80);
    chk("t1_csn_low0", 32'(a_lows[0]), 32'd164);
    chk("t1_csn_low1", 32'(a_lows[1]), 32'd164);
    chk("t1_csn_low2", 32'(a_lows[2]), 32'd164);
    chk("t1_gap_after_rst",  32'(a_gaps[0]), 32'd42);
    chk("t1_gap_normal",     32'(a_gaps[1]), 32'd18);
    chk("t1_done_pulses",    32'(a_done_n),  32'd1);
    chk("t1_no_rd_valid",    32'(a_rdv_n),   32'd0);
    chk("t1_rom_addr_home",  32'(a_rom_addr), 32'd0);
    chk("t1_ready_idle",     32'(a_req_ready), 32'd1);

    // 2: single readback frame, slave returns 0xA5 in the data field
    @(posedge clk); #1;
    clear_a();
    a_resp = 20'h000A5;
    @(negedge clk) begin a_req_valid = 1'b1; a_req_data = 20'h80055; end
    @(negedge clk) a_req_valid = 1'b0;
    chk("t2_busy_after_req", 32'(a_busy), 32'd1);
    wait_idle(1'b0, 1000, "t2_idle_timeout");
    chk("t2_frame_count", 32'(a_frames.size()), 32'd1);
    chk("t2_frame",       a_frames[0], 32'h80055);
    chk("t2_csn_low",     32'(a_lows[0]), 32'd164);
    chk("t2_rd_valid_n",  32'(a_rdv_n), 32'd1);
    chk("t2_rd_data",     32'(a_rd_data), 32'hA5);
    chk("t2_no_done",     32'(a_done_n), 32'd0);

    // 3: start and request together: table first, request held and sent once afterwards
    @(posedge clk); #1;
    clear_a();
    a_resp = '0;
    @(negedge clk) begin a_start = 1'b1; a_req_valid = 1'b1; a_req_data = 20'h12345; end
    @(negedge clk) a_start = 1'b0;
    chk("t3_ready_low_in_run", 32'(a_req_ready), 32'd0);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (a_req_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk("t3_ready_timeout", 32'(ok), 32'd1);
    chk("t3_table_before_req", 32'(a_frames.size()), 32'd3);
    @(negedge clk) a_req_valid = 1'b0;
    wait_idle(1'b0, 1000, "t3_idle_timeout");
    chk("t3_frame_count", 32'(a_frames.size()), 32'd4);
    chk("t3_first_table", a_frames[0], 32'h00002);
    chk("t3_req_frame",   a_frames[3], 32'h12345);
    chk("t3_done_pulses", 32'(a_done_n), 32'd1);

    // 4: start pulses during a run are ignored
    @(posedge clk); #1;
    clear_a();
    pulse_start_a();
    for (int k = 0; k < 3; k++) begin
      repeat (100) @(negedge clk);
      pulse_start_a();
    end
    wait_idle(1'b0, 3000, "t4_idle_timeout");
    repeat (20) @(negedge clk);
    chk("t4_frame_count", 32'(a_frames.size()), 32'd3);
    chk("t4_done_pulses", 32'(a_done_n), 32'd1);
    chk("t4_stays_idle",  32'(a_busy), 32'd0);

    // 5: reset at bit 10 of the second frame aborts; new start begins at index 0
    @(posedge clk); #1;
    clear_a();
    pulse_start_a();
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (a_frames.size() == 1 && a_bits == 10 && !a_csn) begin ok = 1'b1; break; end
    end
    chk("t5_trigger_timeout", 32'(ok), 32'd1);
    a_rst = 1'b1;
    @(posedge clk); #1;
    chk("t5_csn_abort",  32'(a_csn),  32'd1);
    chk("t5_sclk_abort", 32'(a_sclk), 32'd0);
    chk("t5_busy_abort", 32'(a_busy), 32'd0);
    chk("t5_rom_addr",   32'(a_rom_addr), 32'd0);
    @(negedge clk) a_rst = 1'b0;
    chk("t5_no_done",     32'(a_done_n), 32'd0);
    chk("t5_no_rd_valid", 32'(a_rdv_n),  32'd0);
    @(posedge clk); #1;
    clear_a();
    pulse_start_a();
    wait_idle(1'b0, 3000, "t5_idle_timeout");
    chk("t5_frame_count", 32'(a_frames.size()), 32'd3);
    chk("t5_frame0",      a_frames[0], 32'h00002);
    chk("t5_frame2",      a_frames[2], 32'h30B80);
    chk("t5_done_pulses", 32'(a_done_n), 32'd1);

    // 6: CLK_DIV=1, 16-bit frames: SCLK period 2, CSn low 33
    @(negedge clk) b_start = 1'b1;
    @(negedge clk) b_start = 1'b0;
    wait_idle(1'b1, 500, "t6_idle_timeout");
    chk("t6_frame_count", 32'(b_frames.size()), 32'd2);
    chk("t6_frame0",      b_frames[0], 32'h0000A5C3);
    chk("t6_frame1",      b_frames[1], 32'h00001234);
    chk("t6_csn_low0",    32'(b_lows[0]), 32'd33);
    chk("t6_csn_low1",    32'(b_lows[1]), 32'd33);
    chk("t6_gap_after_rst", 32'(b_gaps[0]), 32'd7);
    chk("t6_sclk_period_min", 32'(b_pmin), 32'd2);
    chk("t6_sclk_period_max", 32'(b_pmax), 32'd2);
    chk("t6_done_pulses", 32'(b_done_n), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
